// File: rtl/uart_tx_unit.sv
// Byte-wide UART transmitter: circular transmit FIFO feeding an 8N1 serializer.
// Optional even-parity bit (8E1 frame) when UART_TX_PARITY_EN is defined.
module uart_tx_unit #(
  parameter int DEPTH        = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_fifo_write_en,
  input  logic [7:0]             uart_fifo_data,
  output logic                   tx_line,
  output logic                   tx_ready,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
`ifdef UART_TX_PARITY_EN
  logic            r_par;
`endif
  logic            w_full, w_push, w_pop, w_tick;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot for a push.
  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = uart_fifo_write_en && !w_full && !rst;
  assign w_tick = (r_baud == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= uart_fifo_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: if (r_count != '0) begin
        w_pop  = 1'b1;
        w_next = START;
      end
      START: if (w_tick) w_next = DATA;
      DATA: if (w_tick && r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
        w_next = PARITY;
`else
        w_next = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_tick) w_next = STOP;
`endif
      STOP: if (w_tick) begin
        // Chain straight into the next start bit when more bytes are queued.
        if (r_count != '0) begin
          w_pop  = 1'b1;
          w_next = START;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_baud <= (r_state == IDLE || w_tick) ? '0 : r_baud + 1'b1;
      if (r_state != DATA)  r_bit <= '0;
      else if (w_tick)      r_bit <= r_bit + 1'b1;
      if (w_pop) begin
        r_shift <= r_mem[r_rptr];
`ifdef UART_TX_PARITY_EN
        r_par   <= ^r_mem[r_rptr];
`endif
      end else if (r_state == DATA && w_tick) begin
        r_shift <= r_shift >> 1;
      end
      // Line follows the current state one cycle later, so it only moves on bit boundaries.
      case (r_state)
        START:   r_tx <= 1'b0;
        DATA:    r_tx <= r_shift[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  r_tx <= r_par;
`endif
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign tx_line    = r_tx;
  assign tx_ready   = !w_full;
  assign tx_busy    = (r_state != IDLE);
  assign fifo_count = r_count;
endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit at DEPTH=4, CLKS_PER_BIT=4.
// Define UART_TX_PARITY_EN for both bench and design to exercise 11-bit frames.
module tb_uart_tx_unit;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_line, tx_ready, tx_busy;
  logic [2:0] fifo_count;
  int         checks = 0;
  int         failures = 0;

  uart_tx_unit #(.DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .uart_fifo_write_en(wr_en), .uart_fifo_data(wr_data),
    .tx_line(tx_line), .tx_ready(tx_ready), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  // Samples one frame of the line, one sample per clock, starting at sample index 'start'.
  task automatic frame(input logic [7:0] b, input int start, input string tag);
    logic [10:0] bits;
    logic [63:0] got, exp;
    bits = 11'h7FF;
    bits[0] = 1'b0;
    bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
    bits[9] = ^b;
`endif
    got = '0;
    exp = '0;
    for (int k = 0; k < FRAME; k++) exp[k] = bits[k / CPB];
    for (int k = 0; k < start; k++) got[k] = exp[k];
    for (int k = start; k < FRAME; k++) begin
      got[k] = tx_line;
      tick();
    end
    chk(tag, got, exp);
  endtask

  task automatic idle_watch(input int n, input string tag);
    int bad;
    bad = 0;
    repeat (n) begin
      if (tx_line !== 1'b1 || tx_busy !== 1'b0) bad++;
      tick();
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    // Reset state, and a push during reset must be ignored
    repeat (3) tick();
    wr_en = 1'b1; wr_data = 8'hFF;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    chk("rst_line", tx_line, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_count", fifo_count, 0);
    tick(); tick();
    chk("rst_push_ignored", {fifo_count, tx_busy}, 0);

    // Single byte, latency and frame shape
    push(8'h55);
    chk("lat_n_line", tx_line, 1);
    chk("lat_n_count", fifo_count, 1);
    tick();
    chk("lat_n1_line", tx_line, 1);
    chk("lat_n1_busy", tx_busy, 1);
    chk("lat_n1_count", fifo_count, 0);
    tick();
    frame(8'h55, 0, "frame_55");
    chk("after_55_busy", tx_busy, 0);
    chk("after_55_line", tx_line, 1);

    // Three consecutive pushes, back-to-back frames
    push(8'h01);
    chk("b2b_cnt1", fifo_count, 1);
    push(8'h02);
    chk("b2b_cnt_pushpop", fifo_count, 1);
    push(8'h03);
    chk("b2b_cnt_peak", fifo_count, 2);
    frame(8'h01, 0, "frame_01");
    frame(8'h02, 0, "frame_02");
    frame(8'h03, 0, "frame_03");
    chk("b2b_idle", {fifo_count, tx_busy, tx_line}, 1);

    // Six pushes: fill to 4, sixth dropped
    push(8'h10); push(8'h11); push(8'h12); push(8'h13);
    chk("fill_cnt3", fifo_count, 3);
    push(8'h14);
    chk("fill_cnt4", fifo_count, 4);
    chk("fill_ready0", tx_ready, 0);
    push(8'h15);
    chk("fill_drop_cnt", fifo_count, 4);
    chk("fill_drop_ready", tx_ready, 0);
    frame(8'h10, 3, "frame_10");
    chk("fill_ready_back", tx_ready, 1);
    frame(8'h11, 0, "frame_11");
    frame(8'h12, 0, "frame_12");
    frame(8'h13, 0, "frame_13");
    frame(8'h14, 0, "frame_14");
    idle_watch(2 * FRAME, "fill_only5");

    // Push while full collides with the STOP-end pop
    push(8'h20); push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    repeat (FRAME - 4) tick();
    chk("coll_pre_cnt", fifo_count, 4);
    push(8'h99);
    chk("coll_cnt", fifo_count, 3);
    chk("coll_ready", tx_ready, 1);
    chk("coll_stop_line", tx_line, 1);
    tick();
    frame(8'h21, 0, "frame_21");
    frame(8'h22, 0, "frame_22");
    frame(8'h23, 0, "frame_23");
    frame(8'h24, 0, "frame_24");
    idle_watch(2 * FRAME, "coll_no_99");

    // Reset during data bit 3 of 0xA5 with two bytes queued
    push(8'hA5); push(8'h01); push(8'h02);
    chk("mid_cnt", fifo_count, 2);
    repeat (17) tick();
    chk("mid_bit3", tx_line, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_line", tx_line, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_busy", tx_busy, 0);
    idle_watch(2 * FRAME, "mid_no_frames");

    // Byte with odd popcount (parity 1 when enabled)
    push(8'h07);
    tick(); tick();
    frame(8'h07, 0, "frame_07");
    chk("after_07_idle", {fifo_count, tx_busy, tx_line}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
